blink_mode_sequencer: RTL and testbench

- Rate-mode controller for the LED blink datapath: samples the 2-bit mode switches and generates a single-cycle tick at one of three programmable divide ratios.
- On each tick it toggles mode_clock and advances a walking-one pattern on the 16 LEDs.
- Supports a hold input that freezes sequencing without losing the position.
- Sits between the board switches/buttons and the LED bank, replacing free-running divider logic.

---
 rtl/blink_mode_sequencer_if.sv | 29 ++
 rtl/blink_mode_sequencer.sv | 131 +++++++++++++
 tb/tb_blink_mode_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_mode_sequencer_if.sv
// Switch/button and LED-bank signal bundle for the blink mode sequencer.
// master: board side (drives SW/HOLD, observes the LED outputs).
// slave:  the sequencer itself.
interface blink_mode_sequencer_if;
  logic [1:0]  SW;
  logic        HOLD;
  logic [15:0] LD;
  logic        mode_clock;
  logic        tick;
  logic [1:0]  mode;

  modport master (
    output SW,
    output HOLD,
    input  LD,
    input  mode_clock,
    input  tick,
    input  mode
  );

  modport slave (
    input  SW,
    input  HOLD,
    output LD,
    output mode_clock,
    output tick,
    output mode
  );
endinterface

// File: rtl/blink_mode_sequencer.sv
// Blink mode sequencer: picks one of three divide ratios from the mode
// switches, emits a one-cycle tick at each terminal count, toggles
// mode_clock and walks a single lit LED on every tick. HOLD freezes the
// count and LED position without losing them.
//
// Optional build macro LD_PINGPONG_EN: the walking one bounces between
// LD[0] and LD[15] instead of rotating (30-tick period).
//
// CNT_W must be wide enough that 2^CNT_W exceeds the largest divide ratio;
// ratios below 2 are not supported.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | mode==0; counter parked at 0, no ticks, LD held
// RUN     | mode!=0, HOLD low; counter advancing, ticks at terminal count
// HOLD_ST | mode!=0, HOLD high; counter/LD/mode_clock frozen, no ticks
module blink_mode_sequencer #(
  parameter int DIV_A = 1000,
  parameter int DIV_B = 500,
  parameter int DIV_C = 200,
  parameter int CNT_W = 16
) (
  input logic                  CLOCK,
  input logic                  RESET_N,
  blink_mode_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD_ST = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TC_A = CNT_W'(DIV_A - 1);
  localparam logic [CNT_W-1:0] TC_B = CNT_W'(DIV_B - 1);
  localparam logic [CNT_W-1:0] TC_C = CNT_W'(DIV_C - 1);

  state_t           state;
  logic [1:0]       sw_q;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] term_cnt;
  logic [15:0]      led_step;

  // Terminal count for the active mode; mode 0 never counts so its value is moot.
  always_comb begin
    term_cnt = TC_A;
    case (bus.mode)
      2'd2:    term_cnt = TC_B;
      2'd3:    term_cnt = TC_C;
      default: term_cnt = TC_A;
    endcase
  end

`ifdef LD_PINGPONG_EN
  logic dir;       // 0 = moving toward LD[15], 1 = moving toward LD[0]
  logic go_right;

  // Next LED position: reverse at either end instead of wrapping.
  always_comb begin
    go_right = dir ? ~bus.LD[0] : bus.LD[15];
    led_step = go_right ? {1'b0, bus.LD[15:1]} : {bus.LD[14:0], 1'b0};
  end
`else
  // Next LED position: plain rotate left, LD[15] wraps into LD[0].
  always_comb begin
    led_step = {bus.LD[14:0], bus.LD[15]};
  end
`endif

  // Switch sampling, mode latch, divider and LED/mode_clock sequencing.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      sw_q           <= 2'd0;
      bus.mode       <= 2'd0;
      counter        <= '0;
      bus.tick       <= 1'b0;
      bus.mode_clock <= 1'b0;
      bus.LD         <= 16'h0001;
      state          <= IDLE;
`ifdef LD_PINGPONG_EN
      dir            <= 1'b0;
`endif
    end else begin
      sw_q     <= bus.SW;
      bus.tick <= 1'b0;
      // A mode change restarts the divider and takes priority over a
      // coincident terminal count.
      if (sw_q != bus.mode) begin
        bus.mode <= sw_q;
        counter  <= '0;
        if (sw_q == 2'd0) begin
          state          <= IDLE;
          bus.mode_clock <= 1'b0;
        end else if (bus.HOLD) begin
          state <= HOLD_ST;
        end else begin
          state <= RUN;
        end
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
          end
          RUN, HOLD_ST: begin
            if (bus.HOLD) begin
              state <= HOLD_ST;
            end else begin
              state <= RUN;
              if (counter == term_cnt) begin
                bus.tick       <= 1'b1;
                counter        <= '0;
                bus.mode_clock <= ~bus.mode_clock;
                bus.LD         <= led_step;
`ifdef LD_PINGPONG_EN
                dir            <= go_right;
`endif
              end else begin
                counter <= counter + CNT_W'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_mode_sequencer.sv
// Bench for blink_mode_sequencer: directed scenarios plus a randomized
// phase, every cycle compared against a tick-counting reference model.
module tb_blink_mode_sequencer;

  logic CLOCK = 1'b0;
  logic RESET_N;

  blink_mode_sequencer_if bus ();

  blink_mode_sequencer dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: mode pipeline, progress toward the next tick, total tick count.
  logic [1:0] m_sw_d;
  logic [1:0] m_mode;
  int         m_prog;
  logic       m_mc;
  logic       m_tick;
  int         m_ticks;

  function automatic int div_of(logic [1:0] m);
    case (m)
      2'd1:    return 1000;
      2'd2:    return 500;
      2'd3:    return 200;
      default: return 0;
    endcase
  endfunction

  // LED pattern after s ticks since reset.
  function automatic logic [15:0] led_of(int s);
    logic [15:0] one;
    int pos;
    one = 16'h0001;
`ifdef LD_PINGPONG_EN
    pos = s % 30;
    if (pos > 15) pos = 30 - pos;
`else
    pos = s % 16;
`endif
    return one << pos;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [1:0] new_mode;
    if (!RESET_N) begin
      m_sw_d  = 2'd0;
      m_mode  = 2'd0;
      m_prog  = 0;
      m_mc    = 1'b0;
      m_tick  = 1'b0;
      m_ticks = 0;
    end else begin
      new_mode = m_sw_d;
      m_sw_d   = bus.SW;
      m_tick   = 1'b0;
      if (new_mode != m_mode) begin
        m_mode = new_mode;
        m_prog = 0;
        if (new_mode == 2'd0) m_mc = 1'b0;
      end else if (m_mode != 2'd0 && !bus.HOLD) begin
        m_prog++;
        if (m_prog == div_of(m_mode)) begin
          m_prog = 0;
          m_tick = 1'b1;
          m_mc   = ~m_mc;
          m_ticks++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    model_edge();
    #1;
    cyc++;
    chk("LD",         32'(bus.LD),         32'(led_of(m_ticks)));
    chk("mode_clock", 32'(bus.mode_clock), 32'(m_mc));
    chk("tick",       32'(bus.tick),       32'(m_tick));
    chk("mode",       32'(bus.mode),       32'(m_mode));
  endtask

  task automatic wait_tick(output int t, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick && n < budget);
    chk("tick_seen", 32'(bus.tick), 32'h1);
    t = cyc;
  endtask

  initial begin
    int t, t_prev, t_sw, t_rel;
    logic [15:0] ld_hold;

    bus.SW   = 2'd0;
    bus.HOLD = 1'b0;
    RESET_N  = 1'b0;
    repeat (3) step();
    chk("rst_LD",   32'(bus.LD),         32'h0001);
    chk("rst_mc",   32'(bus.mode_clock), 32'h0);
    chk("rst_tick", 32'(bus.tick),       32'h0);
    chk("rst_mode", 32'(bus.mode),       32'h0);
    RESET_N = 1'b1;
    repeat (7) step();

    // Mode 1: latency, period, LD wrap after 16 ticks, mode_clock halves the tick rate.
    bus.SW = 2'd1;
    t_sw = cyc;
    step();
    step();
    chk("mode_latency", 32'(bus.mode), 32'h1);
    wait_tick(t, 1100);
    chk("first_tick_lat", 32'(t - t_sw), 32'd1002);
    chk("LD_tick1", 32'(bus.LD), 32'h0002);
    t_prev = t;
    for (int k = 2; k <= 16; k++) begin
      wait_tick(t, 1100);
      chk("period_A", 32'(t - t_prev), 32'd1000);
      chk("mc_phase", 32'(bus.mode_clock), 32'(k % 2));
      t_prev = t;
    end
`ifdef LD_PINGPONG_EN
    chk("LD_tick16", 32'(bus.LD), 32'h4000);
`else
    chk("LD_tick16", 32'(bus.LD), 32'h0001);
`endif

    // Mode 2 then mode 3: counter restarts on each change.
    bus.SW = 2'd2;
    t_sw = cyc;
    wait_tick(t, 600);
    chk("lat_B", 32'(t - t_sw), 32'd502);
    t_prev = t;
    repeat (2) begin
      wait_tick(t, 600);
      chk("period_B", 32'(t - t_prev), 32'd500);
      t_prev = t;
    end
    bus.SW = 2'd3;
    t_sw = cyc;
    wait_tick(t, 300);
    chk("lat_C", 32'(t - t_sw), 32'd202);
    t_prev = t;
    repeat (2) begin
      wait_tick(t, 300);
      chk("period_C", 32'(t - t_prev), 32'd200);
      t_prev = t;
    end

    // Hold at counter 150 for 50 cycles.
    repeat (150) step();
    ld_hold = bus.LD;
    bus.HOLD = 1'b1;
    repeat (50) begin
      step();
      chk("hold_no_tick", 32'(bus.tick), 32'h0);
    end
    chk("hold_LD", 32'(bus.LD), 32'(ld_hold));
    bus.HOLD = 1'b0;
    t_rel = cyc;
    wait_tick(t, 300);
    chk("hold_resume", 32'(t - t_rel), 32'd50);

    // Drop to idle while mode_clock is high.
    if (!bus.mode_clock) wait_tick(t, 300);
    chk("mc_high_pre_idle", 32'(bus.mode_clock), 32'h1);
    ld_hold = bus.LD;
    bus.SW = 2'd0;
    step();
    step();
    chk("idle_mode", 32'(bus.mode), 32'h0);
    chk("idle_mc", 32'(bus.mode_clock), 32'h0);
    repeat (1200) step();
    chk("idle_LD", 32'(bus.LD), 32'(ld_hold));

    // Mode update landing on the terminal-count cycle, then a reset mid-count.
    bus.SW = 2'd3;
    wait_tick(t, 300);
    repeat (198) step();
    bus.SW = 2'd2;
    step();
    step();
    chk("tc_clash_tick", 32'(bus.tick), 32'h0);
    chk("tc_clash_mode", 32'(bus.mode), 32'h2);
    repeat (100) step();
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    chk("mid_rst_LD",   32'(bus.LD),         32'h0001);
    chk("mid_rst_mode", 32'(bus.mode),       32'h0);
    chk("mid_rst_tick", 32'(bus.tick),       32'h0);
    chk("mid_rst_mc",   32'(bus.mode_clock), 32'h0);

    // Mode 3 for 32 ticks from a clean reset.
    RESET_N = 1'b0;
    bus.SW = 2'd0;
    repeat (2) step();
    RESET_N = 1'b1;
    bus.SW = 2'd3;
    for (int k = 1; k <= 32; k++) begin
      wait_tick(t, 300);
      if (k == 15) chk("LD_t15", 32'(bus.LD), 32'h8000);
`ifdef LD_PINGPONG_EN
      if (k == 30) chk("LD_t30", 32'(bus.LD), 32'h0001);
      if (k == 32) chk("LD_t32", 32'(bus.LD), 32'h0004);
`else
      if (k == 30) chk("LD_t30", 32'(bus.LD), 32'h4000);
      if (k == 32) chk("LD_t32", 32'(bus.LD), 32'h0001);
`endif
    end

    // Randomized switches, hold pulses and occasional resets.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) bus.SW = 2'($urandom_range(0, 3));
      else if (r < 8) bus.HOLD = 1'($urandom_range(0, 1));
      else if (r == 9 && $urandom_range(0, 3) == 0) begin
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
      end
      repeat ($urandom_range(1, 150)) step();
    end
    bus.HOLD = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
